// File: rtl/mips_state_loader_if.sv
// Loader bus bundle: boot word stream in, register-file and data-memory write ports out.
// master = loader side, slave = stream source / memory side.
// Widths follow the register-file and data-memory address sizes.
interface mips_state_loader_if #(
  parameter int REG_AW  = 5,
  parameter int DMEM_AW = 5
);
  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_data;
  logic               s_last;
  logic               reg_we;
  logic [REG_AW-1:0]  reg_addr;
  logic [31:0]        reg_wdata;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [7:0]         dmem_wdata;

  modport master (
    input  s_valid, s_data, s_last,
    output s_ready, reg_we, reg_addr, reg_wdata, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    output s_valid, s_data, s_last,
    input  s_ready, reg_we, reg_addr, reg_wdata, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/mips_state_loader.sv
// Boot initialiser: zeroes the register file and data memory, then streams words into memory.
// Latency: s_ready rises 1+REG_COUNT+DMEM_BYTES cycles after start; one word per 5 cycles.
// Backpressure: s_ready is high only in LOAD_WAIT and is a pure function of state.
module mips_state_loader #(
  parameter int REG_COUNT  = 32,
  parameter int REG_AW     = 5,
  parameter int DMEM_BYTES = 32,
  parameter int DMEM_AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mips_state_loader_if.master  bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 overflow,
  output logic [DMEM_AW-2:0]   word_count
);

  localparam int WORDS = DMEM_BYTES / 4;
  localparam int CW    = (REG_AW > DMEM_AW) ? REG_AW : DMEM_AW;
  localparam int WCW   = DMEM_AW - 1;

  typedef enum logic [2:0] {
    IDLE, CLR_REG, CLR_MEM, LOAD_WAIT, LOAD_WR, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt;       // register index, byte address, or byte lane in LOAD_WR
  logic [31:0] word_q;
  logic        last_q;
  logic        hs;
  logic        full;
  logic        reg_end;
  logic        mem_end;
  logic        lane_end;

  assign hs       = bus.s_valid & bus.s_ready;
  assign full     = (word_count == WCW'(WORDS));
  assign reg_end  = (cnt == CW'(REG_COUNT - 1));
  assign mem_end  = (cnt == CW'(DMEM_BYTES - 1));
  assign lane_end = (cnt[1:0] == 2'd3);

  // State register; reset drops straight to IDLE, abandoning any write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: clear regs, clear memory, then alternate accept/write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = CLR_REG;
      CLR_REG:   if (reg_end) state_nxt = CLR_MEM;
      CLR_MEM:   if (mem_end) state_nxt = LOAD_WAIT;
      LOAD_WAIT: begin
        if (hs) begin
          if (!full)            state_nxt = LOAD_WR;
          else if (bus.s_last)  state_nxt = DONE;
        end
      end
      LOAD_WR:   if (lane_end) state_nxt = last_q ? DONE : LOAD_WAIT;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset clears them without waiting for a clock.
  always_comb begin
    bus.s_ready    = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_addr   = '0;
    bus.reg_wdata  = '0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    cpu_hold       = (state != IDLE);
    done           = 1'b0;
    case (state)
      CLR_REG: begin
        bus.reg_we   = 1'b1;
        bus.reg_addr = cnt[REG_AW-1:0];
      end
      CLR_MEM: begin
        bus.dmem_we   = 1'b1;
        bus.dmem_addr = cnt[DMEM_AW-1:0];
      end
      LOAD_WAIT: bus.s_ready = 1'b1;
      LOAD_WR: begin
        bus.dmem_we    = 1'b1;
        // Little-endian: lane b of the word lands at word_count*4 + b.
        bus.dmem_addr  = {word_count[DMEM_AW-3:0], cnt[1:0]};
        bus.dmem_wdata = word_q[{cnt[1:0], 3'b000} +: 8];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shared counter, latched stream word, word count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
          end
        end
        CLR_REG: cnt <= reg_end ? '0 : cnt + 1'b1;
        CLR_MEM: cnt <= mem_end ? '0 : cnt + 1'b1;
        LOAD_WAIT: begin
          if (hs) begin
            if (!full) begin
              word_q <= bus.s_data;
              last_q <= bus.s_last;
              cnt    <= '0;
            end else begin
              // Memory already full: swallow the word, flag it, write nothing.
              overflow <= 1'b1;
            end
          end
        end
        LOAD_WR: begin
          if (lane_end) begin
            cnt        <= '0;
            word_count <= word_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
